// File: rtl/armleocpu_aclint_if.sv
// AXI4-Lite bus bundle between a bus master and the ACLINT register block.
`default_nettype none

interface armleocpu_aclint_if;
  logic [31:0] AXI_AWADDR;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID, input AXI_AWREADY,
    output AXI_WDATA, AXI_WSTRB, AXI_WVALID, input AXI_WREADY,
    input AXI_BRESP, AXI_BVALID, output AXI_BREADY,
    output AXI_ARADDR, AXI_ARVALID, input AXI_ARREADY,
    input AXI_RDATA, AXI_RRESP, AXI_RVALID, output AXI_RREADY
  );

  modport slave (
    input AXI_AWADDR, AXI_AWVALID, output AXI_AWREADY,
    input AXI_WDATA, AXI_WSTRB, AXI_WVALID, output AXI_WREADY,
    output AXI_BRESP, AXI_BVALID, input AXI_BREADY,
    input AXI_ARADDR, AXI_ARVALID, output AXI_ARREADY,
    output AXI_RDATA, AXI_RRESP, AXI_RVALID, input AXI_RREADY
  );
endinterface

`default_nettype wire

// File: rtl/armleocpu_aclint.sv
// ============================================================================
// Module  : armleocpu_aclint
// Purpose : ACLINT MSWI/SSWI/MTIMER block with a shared prescaled 64-bit mtime
//           and per-hart mtimecmp, behind an AXI4-Lite slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_aclint #(
  parameter int HART_COUNT       = 8,
  parameter int HART_COUNT_WIDTH = 5,
  parameter int TICK_DIV         = 1,
  parameter int SSWI_ENABLE      = 1
) (
  input  wire                    clk,
  input  wire                    rst,
  armleocpu_aclint_if.slave      s_axi,
  output logic [HART_COUNT-1:0]  hart_swi,
  output logic [HART_COUNT-1:0]  hart_sswi,
  output logic [HART_COUNT-1:0]  hart_timeri
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_WRESP      = 2'd1;
  localparam logic [1:0]  c_RRESP      = 2'd2;
  localparam logic [1:0]  c_KIND_MSIP  = 2'd0;
  localparam logic [1:0]  c_KIND_CMP   = 2'd1;
  localparam logic [1:0]  c_KIND_MTIME = 2'd2;
  localparam logic [1:0]  c_KIND_SSIP  = 2'd3;
  localparam logic [1:0]  c_OKAY       = 2'b00;
  localparam logic [1:0]  c_DECERR     = 2'b11;
  localparam logic [11:0] c_HART_LIMIT = 12'(HART_COUNT);
  localparam logic [15:0] c_DIV_LAST   = 16'(TICK_DIV - 1);

  typedef struct packed {
    logic                        ok;
    logic [1:0]                  kind;
    logic                        hi;
    logic [HART_COUNT_WIDTH-1:0] idx;
  } dec_t;

  // Region is selected by addr[15:14]; everything above 64 KiB is unmapped.
  function automatic dec_t decode(input logic [31:2] a);
    dec_t d;
    d = '0;
    if (a[31:16] == 16'h0) begin
      case (a[15:14])
        2'b00: begin
          d.kind = c_KIND_MSIP;
          d.idx  = a[2 +: HART_COUNT_WIDTH];
          d.ok   = (a[13:2] < c_HART_LIMIT);
        end
        2'b01: begin
          d.kind = c_KIND_CMP;
          d.idx  = a[3 +: HART_COUNT_WIDTH];
          d.hi   = a[2];
          d.ok   = ({1'b0, a[13:3]} < c_HART_LIMIT);
        end
        2'b10: begin
          d.kind = c_KIND_MTIME;
          d.hi   = a[2];
          d.ok   = (a[13:3] == 11'h7FF);
        end
        default: begin
          d.kind = c_KIND_SSIP;
          d.idx  = a[2 +: HART_COUNT_WIDTH];
          d.ok   = (SSWI_ENABLE != 0) && (a[13:2] < c_HART_LIMIT);
        end
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [1:0]            r_state;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;
  logic [15:0]           r_presc;
  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp [HART_COUNT];
  logic [HART_COUNT-1:0] r_swi;
  logic [HART_COUNT-1:0] r_sswi;
  logic [HART_COUNT-1:0] r_timeri;

  dec_t                  w_wdec;
  dec_t                  w_rdec;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_wr_hit;
  logic                  w_tick;
  logic                  w_mtime_wr;
  logic [31:0]           w_rd_data;
  logic                  w_unused;

  assign w_wdec      = decode(s_axi.AXI_AWADDR[31:2]);
  assign w_rdec      = decode(s_axi.AXI_ARADDR[31:2]);
  assign w_unused    = ^{s_axi.AXI_AWADDR[1:0], s_axi.AXI_ARADDR[1:0]};
  assign w_wr_accept = (r_state == c_IDLE) && s_axi.AXI_AWVALID && s_axi.AXI_WVALID;
  assign w_rd_accept = (r_state == c_IDLE) && !(s_axi.AXI_AWVALID && s_axi.AXI_WVALID)
                       && s_axi.AXI_ARVALID;
  assign w_wr_hit    = w_wr_accept && w_wdec.ok;
  assign w_tick      = (r_presc == c_DIV_LAST);
  assign w_mtime_wr  = w_wr_hit && (w_wdec.kind == c_KIND_MTIME);

  assign s_axi.AXI_AWREADY = w_wr_accept;
  assign s_axi.AXI_WREADY  = w_wr_accept;
  assign s_axi.AXI_ARREADY = w_rd_accept;
  assign s_axi.AXI_BVALID  = r_bvalid;
  assign s_axi.AXI_BRESP   = r_bresp;
  assign s_axi.AXI_RVALID  = r_rvalid;
  assign s_axi.AXI_RRESP   = r_rresp;
  assign s_axi.AXI_RDATA   = r_rdata;

  assign hart_swi    = r_swi;
  assign hart_sswi   = (SSWI_ENABLE != 0) ? r_sswi : '0;
  assign hart_timeri = r_timeri;

  always_comb begin
    w_rd_data = '0;
    case (w_rdec.kind)
      c_KIND_MTIME: w_rd_data = w_rdec.hi ? r_mtime[63:32] : r_mtime[31:0];
      default: begin
        for (int h = 0; h < HART_COUNT; h++) begin
          if (w_rdec.idx == HART_COUNT_WIDTH'(h)) begin
            case (w_rdec.kind)
              c_KIND_MSIP: w_rd_data = {31'b0, r_swi[h]};
              c_KIND_SSIP: w_rd_data = {31'b0, r_sswi[h]};
              default:     w_rd_data = w_rdec.hi ? r_mtimecmp[h][63:32]
                                                 : r_mtimecmp[h][31:0];
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= c_OKAY;
      r_rvalid <= 1'b0;
      r_rresp  <= c_OKAY;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_wr_accept) begin
            r_state  <= c_WRESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wdec.ok ? c_OKAY : c_DECERR;
          end else if (w_rd_accept) begin
            r_state  <= c_RRESP;
            r_rvalid <= 1'b1;
            r_rresp  <= w_rdec.ok ? c_OKAY : c_DECERR;
            r_rdata  <= w_rdec.ok ? w_rd_data : 32'h0;
          end
        end
        c_WRESP: begin
          if (s_axi.AXI_BREADY) begin
            r_state  <= c_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        c_RRESP: begin
          if (s_axi.AXI_RREADY) begin
            r_state  <= c_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A write to mtime overrides that cycle's increment; the prescaler is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      r_presc <= w_tick ? 16'h0 : r_presc + 16'h1;
      if (w_mtime_wr) begin
        if (w_wdec.hi)
          r_mtime[63:32] <= merge(r_mtime[63:32], s_axi.AXI_WDATA, s_axi.AXI_WSTRB);
        else
          r_mtime[31:0]  <= merge(r_mtime[31:0], s_axi.AXI_WDATA, s_axi.AXI_WSTRB);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < HART_COUNT; h++) r_mtimecmp[h] <= '1;
      r_swi    <= '0;
      r_sswi   <= '0;
      r_timeri <= '0;
    end else begin
      for (int h = 0; h < HART_COUNT; h++) begin
        r_timeri[h] <= (r_mtime >= r_mtimecmp[h]);
        if (w_wr_hit && (w_wdec.idx == HART_COUNT_WIDTH'(h))) begin
          case (w_wdec.kind)
            c_KIND_MSIP: if (s_axi.AXI_WSTRB[0]) r_swi[h]  <= s_axi.AXI_WDATA[0];
            c_KIND_SSIP: if (s_axi.AXI_WSTRB[0]) r_sswi[h] <= s_axi.AXI_WDATA[0];
            c_KIND_CMP: begin
              if (w_wdec.hi)
                r_mtimecmp[h][63:32] <= merge(r_mtimecmp[h][63:32], s_axi.AXI_WDATA,
                                              s_axi.AXI_WSTRB);
              else
                r_mtimecmp[h][31:0]  <= merge(r_mtimecmp[h][31:0], s_axi.AXI_WDATA,
                                              s_axi.AXI_WSTRB);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_armleocpu_aclint.sv
// Directed plus randomized bench for armleocpu_aclint against a cycle-indexed
// reference model (mtime derived arithmetically from the edge count).
`default_nettype none

module tb_armleocpu_aclint;
  localparam int HC  = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [HC-1:0] hart_swi, hart_sswi, hart_timeri;

  armleocpu_aclint_if bus();

  armleocpu_aclint #(
    .HART_COUNT(HC), .HART_COUNT_WIDTH(5), .TICK_DIV(DIV), .SSWI_ENABLE(1)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus.slave),
    .hart_swi(hart_swi), .hart_sswi(hart_sswi), .hart_timeri(hart_timeri)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  // Reference state: mtime after edge k is base + (ticks in (base_edge, k]),
  // ticks falling on every edge whose index is a multiple of DIV.
  logic [HC-1:0] m_swi, m_sswi;
  logic [63:0]   m_cmp [HC];
  logic [63:0]   m_cmp_old [HC];
  int            m_cmp_w [HC];
  logic [63:0]   m_tv, m_tv_old;
  int            m_tw, m_tw_old;
  logic [HC-1:0] mon_et;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_swi = '0; m_sswi = '0;
    for (int h = 0; h < HC; h++) begin
      m_cmp[h] = '1; m_cmp_old[h] = '1; m_cmp_w[h] = 0;
    end
    m_tv = '0; m_tv_old = '0; m_tw = 0; m_tw_old = 0;
  endfunction

  function automatic logic [63:0] mtime_at(input int k);
    if (k >= m_tw) return m_tv + 64'(k / DIV) - 64'(m_tw / DIV);
    return m_tv_old + 64'(k / DIV) - 64'(m_tw_old / DIV);
  endfunction

  function automatic logic [63:0] cmp_at(input int h, input int k);
    return (k >= m_cmp_w[h]) ? m_cmp[h] : m_cmp_old[h];
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input int e,
                                      output logic [1:0] resp);
    int off, h;
    logic [63:0] nv;
    off  = int'(a[15:0]) & 32'hFFFC;
    resp = 2'b11;
    if (a[31:16] != 16'h0) return;
    if (off < 4*HC) begin
      h = off / 4; resp = 2'b00;
      if (s[0]) m_swi[h] = d[0];
    end else if (off >= 'h4000 && off < 'h4000 + 8*HC) begin
      h = (off - 'h4000) / 8; resp = 2'b00;
      m_cmp_old[h] = m_cmp[h]; m_cmp_w[h] = e;
      if ((off & 4) != 0) m_cmp[h][63:32] = bmerge(m_cmp[h][63:32], d, s);
      else                m_cmp[h][31:0]  = bmerge(m_cmp[h][31:0], d, s);
    end else if (off == 'hBFF8 || off == 'hBFFC) begin
      resp = 2'b00;
      nv = mtime_at(e - 1);
      if (off == 'hBFFC) nv[63:32] = bmerge(nv[63:32], d, s);
      else               nv[31:0]  = bmerge(nv[31:0], d, s);
      m_tv_old = m_tv; m_tw_old = m_tw; m_tv = nv; m_tw = e;
    end else if (off >= 'hC000 && off < 'hC000 + 4*HC) begin
      h = (off - 'hC000) / 4; resp = 2'b00;
      if (s[0]) m_sswi[h] = d[0];
    end
  endfunction

  function automatic void model_read(input logic [31:0] a, input int k,
                                     output logic [1:0] resp, output logic [31:0] data);
    int off, h;
    logic [63:0] v;
    off = int'(a[15:0]) & 32'hFFFC;
    resp = 2'b11; data = '0;
    if (a[31:16] != 16'h0) return;
    if (off < 4*HC) begin
      resp = 2'b00; data = {31'b0, m_swi[off/4]};
    end else if (off >= 'h4000 && off < 'h4000 + 8*HC) begin
      h = (off - 'h4000) / 8; v = cmp_at(h, k); resp = 2'b00;
      data = ((off & 4) != 0) ? v[63:32] : v[31:0];
    end else if (off == 'hBFF8 || off == 'hBFFC) begin
      v = mtime_at(k); resp = 2'b00;
      data = (off == 'hBFFC) ? v[63:32] : v[31:0];
    end else if (off >= 'hC000 && off < 'hC000 + 4*HC) begin
      resp = 2'b00; data = {31'b0, m_sswi[(off - 'hC000)/4]};
    end
  endfunction

  // Interrupt outputs are checked every cycle against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int h = 0; h < HC; h++) mon_et[h] = (mtime_at(ecount - 1) >= cmp_at(h, ecount - 1));
      check("timeri", hart_timeri, mon_et);
      check("swi", hart_swi, m_swi);
      check("sswi", hart_sswi, m_sswi);
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int stall);
    logic [1:0] er;
    int e, n;
    @(negedge clk);
    bus.AXI_AWADDR = a; bus.AXI_AWVALID = 1'b1;
    bus.AXI_WDATA = d; bus.AXI_WSTRB = s; bus.AXI_WVALID = 1'b1;
    #1 check("aw_w_ready", {bus.AXI_AWREADY, bus.AXI_WREADY}, 2'b11);
    @(posedge clk); #1;
    e = ecount;
    bus.AXI_AWVALID = 1'b0; bus.AXI_WVALID = 1'b0;
    model_write(a, d, s, e, er);
    n = 0;
    while (!bus.AXI_BVALID && n < 10) begin @(posedge clk); #1; n++; end
    check("bvalid", bus.AXI_BVALID, 1'b1);
    check("bresp", bus.AXI_BRESP, er);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bus.AXI_BVALID, 1'b1);
      check("bresp_hold", bus.AXI_BRESP, er);
    end
    @(negedge clk); bus.AXI_BREADY = 1'b1;
    @(posedge clk); #1; bus.AXI_BREADY = 1'b0;
    check("bvalid_clear", bus.AXI_BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int stall);
    logic [1:0] er;
    logic [31:0] ed;
    int e;
    @(negedge clk);
    bus.AXI_ARADDR = a; bus.AXI_ARVALID = 1'b1;
    #1 check("arready", bus.AXI_ARREADY, 1'b1);
    @(posedge clk); #1;
    e = ecount;
    bus.AXI_ARVALID = 1'b0;
    model_read(a, e - 1, er, ed);
    check("rvalid", bus.AXI_RVALID, 1'b1);
    check("rresp", bus.AXI_RRESP, er);
    check("rdata", bus.AXI_RDATA, ed);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", bus.AXI_RVALID, 1'b1);
      check("rdata_hold", bus.AXI_RDATA, ed);
      check("rresp_hold", bus.AXI_RRESP, er);
    end
    @(negedge clk); bus.AXI_RREADY = 1'b1;
    @(posedge clk); #1; bus.AXI_RREADY = 1'b0;
    check("rvalid_clear", bus.AXI_RVALID, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int h;
    h = $urandom_range(0, HC + 1);
    case ($urandom_range(0, 5))
      0: return 32'(4*h);
      1: return 32'h4000 + 32'(8*h) + 32'(4*$urandom_range(0, 1));
      2: return $urandom_range(0, 1) ? 32'hBFFC : 32'hBFF8;
      3: return 32'hC000 + 32'(4*h);
      4: return $urandom;
      default: return 32'h1000 + 32'($urandom_range(0, 255) * 4);
    endcase
  endfunction

  initial begin
    logic [1:0] er;
    logic [31:0] ed, a;
    int e, n;
    bus.AXI_AWADDR = '0; bus.AXI_AWVALID = 1'b0; bus.AXI_WDATA = '0;
    bus.AXI_WSTRB = '0; bus.AXI_WVALID = 1'b0; bus.AXI_BREADY = 1'b0;
    bus.AXI_ARADDR = '0; bus.AXI_ARVALID = 1'b0; bus.AXI_RREADY = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", bus.AXI_BVALID, 1'b0);
    check("rst_rvalid", bus.AXI_RVALID, 1'b0);
    check("rst_resp", {bus.AXI_BRESP, bus.AXI_RRESP}, 4'b0);
    check("rst_rdata", bus.AXI_RDATA, 32'h0);
    check("rst_ready", {bus.AXI_AWREADY, bus.AXI_WREADY, bus.AXI_ARREADY}, 3'b0);
    check("rst_irq", {hart_swi, hart_sswi, hart_timeri}, '0);
    @(negedge clk); rst = 1'b0; mon_en = 1'b1;

    axi_read(32'h4000, 0);
    axi_read(32'h4004, 0);
    axi_read(32'hBFF8, 0);

    axi_write(32'h0008, 32'h1, 4'b0001, 0);
    check("swi_h2", hart_swi, 8'h04);
    axi_write(32'h0008, 32'h0, 4'b0000, 0);
    check("swi_strb0", hart_swi, 8'h04);
    axi_write(32'hC014, 32'h1, 4'b0001, 0);
    axi_read(32'hC014, 0);

    axi_write(32'h4004, 32'h1, 4'b1111, 0);
    axi_write(32'h4000, 32'h2, 4'b1111, 0);
    axi_write(32'hBFFC, 32'h0, 4'b1111, 0);
    axi_write(32'hBFF8, 32'hFFFF_FFFF, 4'b1111, 0);
    n = 0;
    while (!hart_timeri[0] && n < 60) begin @(posedge clk); #1; n++; end
    check("timer0_rise", hart_timeri, 8'h01);
    axi_read(32'hBFFC, 0);

    axi_read(32'(4*HC), 0);
    axi_read(32'h1000, 0);
    axi_write(32'(4*HC), 32'h1, 4'b1111, 0);
    axi_write(32'h1000, 32'hFFFF_FFFF, 4'b1111, 0);

    axi_write(32'h4008, $urandom, 4'b1111, 5);
    axi_read(32'h4008, 5);

    // Address without data must not be accepted.
    @(negedge clk); bus.AXI_AWADDR = 32'h0; bus.AXI_AWVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("aw_only_ready", bus.AXI_AWREADY, 1'b0);
      @(negedge clk);
    end
    bus.AXI_AWVALID = 1'b0;
    check("aw_only_bvalid", bus.AXI_BVALID, 1'b0);

    // Write and read offered together: write goes first, read sees its result.
    @(negedge clk);
    bus.AXI_AWADDR = 32'h000C; bus.AXI_WDATA = 32'h1; bus.AXI_WSTRB = 4'b0001;
    bus.AXI_AWVALID = 1'b1; bus.AXI_WVALID = 1'b1;
    bus.AXI_ARADDR = 32'h000C; bus.AXI_ARVALID = 1'b1;
    #1 check("both_ready", {bus.AXI_AWREADY, bus.AXI_ARREADY}, 2'b10);
    @(posedge clk); #1;
    e = ecount;
    bus.AXI_AWVALID = 1'b0; bus.AXI_WVALID = 1'b0;
    model_write(32'h000C, 32'h1, 4'b0001, e, er);
    check("both_bvalid", {bus.AXI_BVALID, bus.AXI_RVALID}, 2'b10);
    check("both_arready_wresp", bus.AXI_ARREADY, 1'b0);
    @(negedge clk); bus.AXI_BREADY = 1'b1;
    @(posedge clk); #1; bus.AXI_BREADY = 1'b0;
    check("both_arready_idle", bus.AXI_ARREADY, 1'b1);
    @(posedge clk); #1;
    e = ecount;
    bus.AXI_ARVALID = 1'b0;
    model_read(32'h000C, e - 1, er, ed);
    check("both_rdata", bus.AXI_RDATA, ed);
    check("both_rresp", bus.AXI_RRESP, er);
    @(negedge clk); bus.AXI_RREADY = 1'b1;
    @(posedge clk); #1; bus.AXI_RREADY = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) axi_write(a, $urandom, 4'($urandom_range(0, 15)), 0);
      else                           axi_read(a, 0);
    end

    // Reset while a write response is pending.
    @(negedge clk);
    bus.AXI_AWADDR = 32'h0004; bus.AXI_WDATA = 32'h1; bus.AXI_WSTRB = 4'b1111;
    bus.AXI_AWVALID = 1'b1; bus.AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    e = ecount;
    bus.AXI_AWVALID = 1'b0; bus.AXI_WVALID = 1'b0;
    model_write(32'h0004, 32'h1, 4'b1111, e, er);
    check("pre_rst_bvalid", bus.AXI_BVALID, 1'b1);
    @(negedge clk); mon_en = 1'b0; rst = 1'b1;
    #1 check("rst_async_bvalid", bus.AXI_BVALID, 1'b0);
    @(posedge clk); #1;
    check("rst2_irq", {hart_swi, hart_sswi, hart_timeri}, '0);
    check("rst2_valid", {bus.AXI_BVALID, bus.AXI_RVALID}, 2'b00);
    @(negedge clk); rst = 1'b0; model_reset(); mon_en = 1'b1;
    axi_read(32'h4000, 0);
    axi_read(32'h4004, 0);
    axi_read(32'h0004, 0);
    axi_read(32'hBFF8, 0);

    @(negedge clk); mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
